// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: one-pass full-row clear and in-place compaction of a
// BLOCKS_W x BLOCKS_H board held in an external row memory.
// The board is scanned bottom-up. Rows that are not full are copied down to
// the write pointer, and full rows are dropped and counted. The vacated rows
// at the top are then zero-filled.
// Optional feature: define LINE_CLEAR_SCORE_EN to add the score_add output.
module line_clear_ctrl #(
    parameter int BLOCKS_W = 10,
    parameter int BLOCKS_H = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4:0]          rd_addr,
    input  logic [BLOCKS_W-1:0] rd_data,
    output logic                wr_en,
    output logic [4:0]          wr_addr,
    output logic [BLOCKS_W-1:0] wr_data,
    output logic [4:0]          lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [10:0]         score_add
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ROW = 5'(BLOCKS_H - 1);

    state_t     state_q, state_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] count_q, count_d;
    logic [4:0] lines_q, lines_d;
    logic       row_full;
    logic       enter_done;

    // A row is full when every cell in it is occupied.
    assign row_full = &rd_data;

    // The pass result is captured on the single transition into DONE.
    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

    // State register (synchronous active-low reset)
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: SCAN always lasts BLOCKS_H cycles, and FILL runs
    // until the write pointer has written row 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SCAN;
            S_SCAN: if (rd_ptr_q == 5'd0)
                        state_d = (count_d != 5'd0) ? S_FILL : S_DONE;
            S_FILL: if (wr_ptr_q == 5'd0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: pointers, the running count and the held result.
    // Reset clears them all, which aborts any pass that is in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            lines_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            lines_q  <= lines_d;
        end
    end

    // Datapath next-state logic. wr_ptr only moves when a row is written, so
    // it never drops below rd_ptr. A kept row therefore never overwrites a
    // row that has not been read yet. Pointers stop at 0 instead of wrapping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        lines_d  = lines_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_ptr_d = LAST_ROW;
                    wr_ptr_d = LAST_ROW;
                    count_d  = '0;
                end
            end
            S_SCAN: begin
                rd_ptr_d = (rd_ptr_q != 5'd0) ? rd_ptr_q - 5'd1 : 5'd0;
                if (row_full)
                    count_d = count_q + 5'd1;
                else if (wr_ptr_q != 5'd0)
                    wr_ptr_d = wr_ptr_q - 5'd1;
            end
            S_FILL: begin
                if (wr_ptr_q != 5'd0) wr_ptr_d = wr_ptr_q - 5'd1;
            end
            default: ;
        endcase
        if (enter_done) lines_d = count_d;
    end

    // Output decode. IDLE and DONE drive no writes, and both addresses are
    // zero outside the states that use them.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_SCAN: begin
                busy    = 1'b1;
                rd_addr = rd_ptr_q;
                if (!row_full) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_ptr_q;
                    wr_data = rd_data;
                end
            end
            S_FILL: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = wr_ptr_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0] score_q, score_d;

    function automatic logic [10:0] score_of(input logic [4:0] n);
        case (n)
            5'd0:    score_of = 11'd0;
            5'd1:    score_of = 11'd40;
            5'd2:    score_of = 11'd100;
            5'd3:    score_of = 11'd300;
            default: score_of = 11'd1200;
        endcase
    endfunction

    // The score is loaded together with lines_cleared and held between passes.
    always_comb begin
        score_d = score_q;
        if (enter_done) score_d = score_of(count_d);
    end

    // Score register
    always_ff @(posedge clk) begin
        if (!reset_n) score_q <= '0;
        else          score_q <= score_d;
    end

    assign score_add = score_q;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: a behavioural board memory, a table of pass
// vectors, and a write scoreboard filled from a reference compaction model.
module tb_line_clear_ctrl;
    localparam int W = 10;
    localparam int H = 20;

    logic         clk = 1'b0;
    logic         reset_n, start;
    logic         busy, done, wr_en;
    logic [4:0]   rd_addr, wr_addr, lines_cleared;
    logic [W-1:0] rd_data, wr_data;
`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0]  score_add;
`endif

    line_clear_ctrl #(.BLOCKS_W(W), .BLOCKS_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
        , .score_add(score_add)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [W-1:0] board [H];
    logic [W-1:0] exp_board [H];

    typedef struct packed { logic [4:0] addr; logic [W-1:0] data; } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [H-1:0] full_mask;
        int           kind;       // 0 others zero, 1 directed pattern, 2 random non-full
        int           exp_lines;
        int           exp_score;
        int           exp_done;   // cycle index of done, first SCAN cycle = 1
    } vec_t;
    vec_t vecs[7];

    assign rd_data = (rd_addr < 5'(H)) ? board[rd_addr] : '0;

    always @(posedge clk)
        if (wr_en && wr_addr < 5'(H)) board[wr_addr] <= wr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Write monitor: every observed write must be the next expected one.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic load_board(input vec_t v);
        for (int r = 0; r < H; r++) begin
            if (v.full_mask[r])  board[r] = '1;
            else if (v.kind == 2) board[r] = W'($urandom) & ~W'(1);
            else                 board[r] = '0;
        end
        if (v.kind == 1) begin
            board[19] = 10'b1000100001;
            board[17] = 10'b0001100000;
            board[15] = 10'b0100000100;
        end
    endtask

    // Reference model: bottom-up compaction, then zero rows at the top.
    task automatic build_expected();
        int wp;
        int cnt;
        wp = H - 1;
        cnt = 0;
        for (int r = H - 1; r >= 0; r--) begin
            if (&board[r]) cnt++;
            else begin
                exp_q.push_back({5'(wp), board[r]});
                exp_board[wp] = board[r];
                wp--;
            end
        end
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back({5'(wp), W'(0)});
            exp_board[wp] = '0;
            wp--;
        end
    endtask

    task automatic run_pass(input vec_t v, input string tag, input bit inject);
        int cyc;
        int d0;
        bit got;
        load_board(v);
        build_expected();
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        got = 0;
        chk({tag, "_busy_after_start"}, 32'(busy), 1);
        for (int n = 0; n < 100; n++) begin
            if (done) begin got = 1; break; end
            start = inject && (cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_done_cycle"}, 32'(cyc), 32'(v.exp_done));
            chk({tag, "_lines_cleared"}, 32'(lines_cleared), 32'(v.exp_lines));
            chk({tag, "_busy_in_done"}, 32'(busy), 0);
            chk({tag, "_wr_en_in_done"}, 32'(wr_en), 0);
            chk({tag, "_writes_left"}, 32'(exp_q.size()), 0);
`ifdef LINE_CLEAR_SCORE_EN
            chk({tag, "_score_add"}, 32'(score_add), 32'(v.exp_score));
`endif
            if (inject) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_idle_busy"}, 32'(busy), 0);
            chk({tag, "_idle_addrs"}, 32'({rd_addr, wr_addr}), 0);
            chk({tag, "_lines_held"}, 32'(lines_cleared), 32'(v.exp_lines));
            chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
            for (int r = 0; r < H; r++)
                chk({tag, $sformatf("_row%0d", r)}, 32'(board[r]), 32'(exp_board[r]));
        end
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{20'h50000, 1, 2,  100,  23};   // directed two-line clear
        vecs[1] = '{20'h00000, 0, 0,  0,    21};   // empty board
        vecs[2] = '{20'hFFFFF, 0, 20, 1200, 41};   // all full
        vecs[3] = '{20'hF0000, 0, 4,  1200, 25};   // bottom four full
        vecs[4] = '{20'h00001, 2, 1,  40,   22};   // only the top row full
        vecs[5] = '{20'h80420, 2, 3,  300,  24};
        vecs[6] = '{20'h8108A, 2, 5,  1200, 26};

        for (int r = 0; r < H; r++) board[r] = '0;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_lines", 32'(lines_cleared), 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("rst_score", 32'(score_add), 0);
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i], $sformatf("vec%0d", i), 1'b0);
            // A pass that clears its full rows must leave exactly these rows.
            if (i == 0) begin
                chk("v0_row19", 32'(board[19]), 32'h221);
                chk("v0_row18", 32'(board[18]), 32'h060);
                chk("v0_row17", 32'(board[17]), 32'h104);
                chk("v0_rows01", 32'({board[0], board[1]}), 0);
            end
            if (i == 3)
                chk("v3_rows0to3", 32'(board[0] | board[1] | board[2] | board[3]), 0);
        end

        // Extra start during SCAN and in the DONE cycle must be ignored.
        run_pass(vecs[5], "ignore_start", 1'b1);

        // Reset asserted in the first FILL cycle aborts the pass.
        begin
            int cyc;
            load_board(vecs[0]);
            build_expected();
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 1;
            for (int n = 0; n < 20; n++) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("rstmid_in_fill", 32'({busy, wr_en}), 3);
            reset_n = 1'b0;
            @(posedge clk); #1;
            chk("rstmid_pending_writes", 32'(exp_q.size()), 1);
            exp_q.delete();
            chk("rstmid_busy", 32'(busy), 0);
            chk("rstmid_wr_en", 32'(wr_en), 0);
            chk("rstmid_lines", 32'(lines_cleared), 0);
            reset_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("rstmid_stays_idle", 32'({busy, done, wr_en}), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
